// File: rtl/res_pkg.sv
// res_pkg: shared widths, reader FSM state encoding and a byte-pick helper
// for the result FIFO reader.
package res_pkg;

  localparam int RESULT_W = 16;
  localparam int BYTE_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    BYTE0,
    BYTE1,
    CKSUM,
    DONE
  } reader_state_t;

  // hi=1 returns the upper byte of a result, hi=0 the lower byte.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [RESULT_W-1:0] w,
                                                  input logic hi);
    return hi ? w[RESULT_W-1:BYTE_W] : w[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/res_fifo_reader_frame_counter.sv
// frame_counter: counts results sent in the current frame.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clear        zero the count (new frame)
//   enable       increment by one
//   count        current count
//   last         high while count == NUM_RESULTS-1
module frame_counter #(
  parameter int NUM_RESULTS = 1352,
  parameter int CNT_W       = $clog2(NUM_RESULTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + CNT_W'(1);
  end

  assign last = (count == CNT_W'(NUM_RESULTS - 1));

endmodule

// File: rtl/res_fifo_reader.sv
// res_fifo_reader: drains the 16-bit result FIFO and streams each result as
// two bytes over a valid/ready byte link. One frame of NUM_RESULTS results is
// sent per start request, followed by a one-cycle frame_done pulse.
//
// Optional feature: define RES_READER_CKSUM_EN to append one checksum byte
// (XOR of all data bytes of the frame) after the last data byte.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           1-cycle frame request, honoured only when idle
//   fifo_empty      result FIFO empty flag
//   fifo_rdata      FIFO read data, valid the cycle after a pop
//   fifo_renable    pop request (only while not empty)
//   tx_data/valid   outgoing byte, held until tx_ready
//   tx_ready        sink ready
//   busy            frame in progress
//   frame_done      1-cycle pulse after the last byte is accepted
module res_fifo_reader
  import res_pkg::*;
#(
  parameter int NUM_RESULTS = 1352,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                fifo_empty,
  input  logic [RESULT_W-1:0] fifo_rdata,
  output logic                fifo_renable,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                frame_done
);

  localparam int CNT_W = $clog2(NUM_RESULTS + 1);

  reader_state_t       state_q;
  logic [RESULT_W-1:0] hold_q;
  logic [CNT_W-1:0]    count;
  logic                last;
  logic                tx_hs;
  logic                start_ok;
  logic                cnt_en;
`ifdef RES_READER_CKSUM_EN
  logic [BYTE_W-1:0]   cksum_q;
`endif

  assign tx_hs    = tx_valid && tx_ready;
  assign start_ok = start && (state_q == IDLE);
  assign cnt_en   = (state_q == BYTE1) && tx_hs;

  // Pop is combinational so a non-empty FIFO is popped the same cycle FETCH
  // sees it; the FSM leaves FETCH on that edge, giving exactly one pop.
  assign fifo_renable = (state_q == FETCH) && !fifo_empty;

  frame_counter #(
    .NUM_RESULTS (NUM_RESULTS),
    .CNT_W       (CNT_W)
  ) u_frame_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok),
    .enable (cnt_en),
    .count  (count),
    .last   (last)
  );

  // tx_data/tx_valid/busy/frame_done are registered alongside the state so
  // they change only on state transitions and stay stable during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef RES_READER_CKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            busy    <= 1'b1;
`ifdef RES_READER_CKSUM_EN
            cksum_q <= '0;
`endif
          end
        end
        FETCH: begin
          if (!fifo_empty) state_q <= LOAD;
        end
        LOAD: begin
          hold_q   <= fifo_rdata;
          tx_data  <= pick_byte(fifo_rdata, MSB_FIRST);
          tx_valid <= 1'b1;
          state_q  <= BYTE0;
        end
        BYTE0: begin
          if (tx_hs) begin
            tx_data <= pick_byte(hold_q, !MSB_FIRST);
            state_q <= BYTE1;
`ifdef RES_READER_CKSUM_EN
            cksum_q <= cksum_q ^ tx_data;
`endif
          end
        end
        BYTE1: begin
          if (tx_hs) begin
`ifdef RES_READER_CKSUM_EN
            cksum_q <= cksum_q ^ tx_data;
`endif
            if (last) begin
`ifdef RES_READER_CKSUM_EN
              // Checksum byte includes the byte being accepted now.
              tx_data <= cksum_q ^ tx_data;
              state_q <= CKSUM;
`else
              tx_valid   <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state_q    <= DONE;
`endif
            end else begin
              tx_valid <= 1'b0;
              state_q  <= FETCH;
            end
          end
        end
`ifdef RES_READER_CKSUM_EN
        CKSUM: begin
          if (tx_hs) begin
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state_q    <= DONE;
          end
        end
`endif
        DONE: begin
          frame_done <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          tx_valid   <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_res_fifo_reader.sv
// Directed bench for res_fifo_reader with NUM_RESULTS=3. A behavioural FIFO
// feeds the DUT; every byte expected on the link is queued when its result is
// written into the FIFO and compared as the DUT's handshakes occur.
module tb_res_fifo_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        fifo_empty;
  logic [15:0] fifo_rdata;
  logic        fifo_renable;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;

  res_fifo_reader #(.NUM_RESULTS(3), .MSB_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_renable (fifo_renable),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: written by the stimulus, popped on renable.
  logic [15:0] mem [0:63];
  int pushes = 0;
  int pops   = 0;
  assign fifo_empty = (pushes == pops);

  always @(posedge clk) begin
    if (fifo_renable) begin
      fifo_rdata <= mem[pops];
      pops       <= pops + 1;
    end
  end

  logic [7:0] exp_q [$];
  logic [7:0] cks;
  int checks   = 0;
  int failures = 0;
  int n_ren    = 0;
  int n_done   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[pushes] = w;
    pushes++;
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    cks = cks ^ w[15:8] ^ w[7:0];
  endtask

  // Sample just before the coming posedge (inputs already final), then
  // advance one clock and return at the following negedge.
  task automatic step();
    #1;
    if (fifo_renable) begin
      n_ren++;
      chk("renable_while_empty", {31'd0, fifo_empty}, 32'd0);
    end
    if (frame_done) n_done++;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
      end else begin
        chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_done(input string tag, input int max);
    int t  = 0;
    int d0 = n_done;
    while (n_done == d0 && t < max) begin
      step();
      t++;
    end
    chk(tag, n_done - d0, 1);
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] b);
    int t = 0;
    while (!(tx_valid && tx_data == b) && t < 60) begin
      step();
      t++;
    end
    chk(tag, {31'd0, tx_valid && tx_data == b}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int ren0;

  initial begin
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1; cks = '0;
    @(negedge clk);

    // 1: reset state
    step(); step();
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_renable", {31'd0, fifo_renable}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    rst = 1'b0;
    step();

    // start and rst in the same cycle: reset wins
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst_beats_start", {31'd0, busy}, 0);

    // 2: basic frame
    push(16'd68); push(16'd2021); push(16'd984);
    ren0 = n_ren;
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 1);
    run_until_done("f2_done", 100);
    chk("f2_ren_count", n_ren - ren0, 3);
    chk("f2_all_bytes", exp_q.size(), 0);
    chk("f2_busy_low", {31'd0, busy}, 0);
    chk("f2_done_pulse", {31'd0, frame_done}, 0);

    // 3: sink stall in BYTE1 of 2021
    push(16'd68); push(16'd2021); push(16'd984);
    ren0 = n_ren;
    pulse_start();
    wait_byte("f3_reach_e5", 8'hE5);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("f3_hold_data", {24'd0, tx_data}, 32'hE5);
      chk("f3_hold_valid", {31'd0, tx_valid}, 1);
      chk("f3_no_renable", {31'd0, fifo_renable}, 0);
    end
    tx_ready = 1'b1;
    run_until_done("f3_done", 100);
    chk("f3_ren_count", n_ren - ren0, 3);
    chk("f3_all_bytes", exp_q.size(), 0);

    // 4: FIFO runs dry after the first result
    push(16'd68);
    ren0 = n_ren;
    pulse_start();
    repeat (8) step();
    chk("f4_stall_renable", {31'd0, fifo_renable}, 0);
    chk("f4_stall_busy", {31'd0, busy}, 1);
    chk("f4_first_sent", exp_q.size(), 0);
    push(16'd2021);
    repeat (6) step();
    chk("f4_resumed", exp_q.size(), 0);
    push(16'd984);
    run_until_done("f4_done", 100);
    chk("f4_ren_count", n_ren - ren0, 3);

    // 5: reset during BYTE0 of the second result
    push(16'd68); push(16'd2021); push(16'd984);
    pulse_start();
    wait_byte("f5_reach_07", 8'h07);
    rst = 1'b1; tx_ready = 1'b0;
    step();
    rst = 1'b0; tx_ready = 1'b1;
    chk("f5_rst_busy", {31'd0, busy}, 0);
    chk("f5_rst_valid", {31'd0, tx_valid}, 0);
    // 2021 was already popped and is lost; 984 remains in the FIFO.
    exp_q.delete();
    exp_q.push_back(8'h03); exp_q.push_back(8'hD8);
    cks = 8'h03 ^ 8'hD8;
    push(16'd100); push(16'd200);
    ren0 = n_ren;
    pulse_start();
    run_until_done("f5_done", 100);
    chk("f5_ren_count", n_ren - ren0, 3);
    chk("f5_all_bytes", exp_q.size(), 0);

    // 6: checksum (when built in) and start while busy
    cks = '0;
    push(16'd68); push(16'd2021); push(16'd984);
`ifdef RES_READER_CKSUM_EN
    exp_q.push_back(cks);
`endif
    ren0 = n_ren;
    pulse_start();
    repeat (3) step();
    pulse_start();
    run_until_done("f6_done", 100);
    chk("f6_ren_count", n_ren - ren0, 3);
    chk("f6_all_bytes", exp_q.size(), 0);
    repeat (4) step();
    chk("f6_stray_start_ignored", {31'd0, busy}, 0);
    chk("f6_no_extra_done", n_done, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
